ibex_fetch_req_ctrl: RTL
========================

// Module: ibex_fetch_req_ctrl
// PURPOSE
//  Instruction-fetch request sequencer for the IF stage. Issues word-aligned
//  requests on the instruction memory bus and tracks up to NUM_REQS in-flight
//  requests. Marks responses made stale by a branch for discard. Pushes the
//  remaining responses into the fetch FIFO (in_* side of ibex_fetch_fifo) and
//  drives its clear. Owns the fetch address; the FIFO owns the PC.
// PARAMETERS
//  NUM_REQS  2  max outstanding bus requests; must match the fetch FIFO's NUM_REQS
// PORTS
//  clk_i           in   1   clock
//  rst_ni          in   1   async reset, active low
//  req_i           in   1   fetch enable from core controller
//  branch_i        in   1   redirect fetch to branch_addr_i (single-cycle pulse)
//  branch_addr_i   in   32  branch target (bit 0 ignored)
//  busy_o          out  1   requests outstanding or bus request pending
//  fifo_clear_o    out  1   to FIFO clear_i
//  fifo_valid_o    out  1   to FIFO in_valid_i
//  fifo_ready_i    in   1   from FIFO in_ready_o
//  fifo_addr_o     out  32  to FIFO in_addr_i
//  fifo_rdata_o    out  32  to FIFO in_rdata_i
//  fifo_err_o      out  1   to FIFO in_err_i
//  instr_req_o     out  1   bus request
//  instr_gnt_i     in   1   bus grant
//  instr_addr_o    out  32  bus address, [1:0]=2'b00
//  instr_rvalid_i  in   1   bus response valid (in order, >=1 cycle after gnt)
//  instr_rdata_i   in   32  response data
//  instr_err_i     in   1   response bus error
// BEHAVIOUR
//  Reset:
//   - FSM=IDLE, fetch_addr_q=0, outstanding count=0, discard flags=0.
//   - All outputs 0.
//  Request and address:
//   - instr_addr_o = {fetch_addr_q[31:2],2'b00} in IDLE/REQ.
//   - fetch_addr_q += 4 on each accepted (non-stale) grant; 32-bit wrap, no flag.
//  Branch:
//   - fifo_clear_o = branch_i (combinational); fifo_addr_o = branch_addr_i.
//   - branch_i loads fetch_addr_q <= {branch_addr_i[31:2],2'b00}.
//   - branch_i sets the discard flag of every request granted but without
//     response. This includes a grant and a response in the same cycle.
//  Issue condition:
//   - can_issue = req_i & fifo_ready_i & (count < NUM_REQS).
//  FSM:
//   - IDLE: instr_req_o = can_issue. Granted same cycle -> stay IDLE.
//     Not granted -> REQ.
//   - REQ: instr_req_o=1, address held stable until gnt (bus rule). Drop of
//     req_i or fifo_ready_i does not deassert. On gnt -> IDLE.
//     branch_i without gnt -> REQ_STALE.
//   - REQ_STALE: hold req_o=1 and the old address in stale_addr_q, captured at
//     branch. On gnt: record the request as discard, -> IDLE. The new target
//     issues from IDLE the next cycle.
//   - branch_i in REQ_STALE: update fetch_addr_q only.
//   - branch_i in IDLE with same-cycle gnt: that request is discarded.
//  Tracking:
//   - count +1 on gnt, -1 on rvalid; both in one cycle -> unchanged.
//   - Discard flags form a NUM_REQS-deep in-order shift queue.
//  Response path:
//   - fifo_valid_o = instr_rvalid_i & ~discard_head & ~branch_i.
//   - Response discarded -> no push, count still decrements.
//   - fifo_rdata_o/fifo_err_o = instr_rdata_i/instr_err_i, zero added latency.
//   - fifo_ready_i is not checked on push; the count limit guarantees space.
//  Errors:
//   - instr_err_i is passed through; fetch continues. Halting is the core's job.
//  Status:
//   - busy_o = (count!=0) | (state!=IDLE).
//  Bus protocol:
//   - rvalid with count==0 is a protocol violation (assertion); ignored.
//  Reset mid-operation:
//   - Async reset clears all state immediately.
//   - Late responses after reset are ignored while count==0.
// TESTING
//  T1 reset, req_i=1, gnt=1 every cycle, rvalid 1 cycle after gnt, branch_i pulse
//     with target 0x100 -> addresses 0x100,0x104,0x108; each rdata pushed the
//     cycle of rvalid.
//  T2 gnt held low 3 cycles -> instr_req_o and instr_addr_o=0x100 stable all
//     3 cycles; fetch_addr advances to 0x104 only after gnt.
//  T3 two outstanding (0x100,0x104), branch to 0x202 -> both responses dropped
//     (fifo_valid_o=0); next request 0x200; fifo_addr_o=0x202 with clear.
//  T4 branch to 0x300 while in REQ for 0x108, gnt 2 cycles later -> 0x108 stays
//     on bus until gnt, response dropped, then request 0x300 issued.
//  T5 fifo_ready_i=0 with count=NUM_REQS -> no new req; count tops at 2;
//     simultaneous gnt+rvalid keeps count constant.
//  T6 instr_err_i=1 on the 0x104 response -> fifo_err_o=1 on that push;
//     rst_ni low mid-burst -> all outputs 0 immediately, count=0.

Source files
------------

// File: rtl/ibex_fetch_req_ctrl.sv
// Instruction-fetch request sequencer for the IF stage.
// Issues word-aligned requests on the instruction bus, tracks up to NUM_REQS
// outstanding requests and marks the responses that a branch makes stale so
// they are dropped. The remaining responses go to the fetch FIFO. This block
// owns the fetch address, and the FIFO owns the PC.
//
// Handshake: the bus request is a valid/ready pair. Once instr_req_o is raised
// and no grant has arrived, the request and its address stay stable until
// instr_gnt_i. Responses come back in order. A response is pushed into the
// FIFO when fifo_valid_o is high. There is no back-pressure on the push,
// because the request is issued only when fifo_ready_i is high and the count
// is below NUM_REQS.
module ibex_fetch_req_ctrl #(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        busy_o,
  output logic        fifo_clear_o,
  output logic        fifo_valid_o,
  input  logic        fifo_ready_i,
  output logic [31:0] fifo_addr_o,
  output logic [31:0] fifo_rdata_o,
  output logic        fifo_err_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i
);

  localparam int unsigned CW = $clog2(NUM_REQS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(NUM_REQS);

  // Encoded FSM state. state_q is kept as a named signal so checkers can bind to it.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    REQ_STALE = 2'd2
  } state_e;

  state_e              state_q;
  logic [31:0]         fetch_addr_q;
  logic [31:0]         stale_addr_q;
  logic [CW-1:0]       count_q;
  logic [NUM_REQS-1:0] discard_q;
  logic [NUM_REQS-1:0] discard_d;

  logic          can_issue;
  logic          req_int;
  logic          gnt_acc;
  logic          rsp_acc;
  logic          new_flag;
  logic [CW-1:0] slot;
  logic [31:0]   cur_addr;

  assign cur_addr  = {fetch_addr_q[31:2], 2'b00};
  assign can_issue = req_i & fifo_ready_i & (count_q < MAX_CNT);
  assign gnt_acc   = req_int & instr_gnt_i;
  // A response with nothing outstanding breaks the bus protocol, so it is ignored.
  assign rsp_acc   = instr_rvalid_i & (count_q != '0);
  // A request granted in REQ_STALE, or granted in the cycle of a branch, is stale.
  assign new_flag  = (state_q == REQ_STALE) | branch_i;
  assign slot      = count_q - CW'(rsp_acc);

  // Raise the bus request: only on demand in IDLE, and held while waiting for the grant.
  always_comb begin
    req_int = 1'b1;
    if (state_q == IDLE) req_int = can_issue;
  end

  // Outputs. All of them are forced low while reset is asserted.
  assign instr_req_o  = req_int & rst_ni;
  assign instr_addr_o = (state_q == REQ_STALE) ? stale_addr_q : cur_addr;
  assign fifo_clear_o = branch_i & rst_ni;
  assign fifo_addr_o  = rst_ni ? branch_addr_i : 32'h0;
  assign fifo_valid_o = rst_ni & rsp_acc & ~discard_q[0] & ~branch_i;
  assign fifo_rdata_o = rst_ni ? instr_rdata_i : 32'h0;
  assign fifo_err_o   = rst_ni & instr_err_i;
  assign busy_o       = (count_q != '0) | (state_q != IDLE);

  // Request FSM. It holds the address stable through grant wait and tracks stale requests.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      stale_addr_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          // A request raised in the cycle of a branch must still hold its old address.
          if (can_issue && !instr_gnt_i) begin
            if (branch_i) begin
              state_q      <= REQ_STALE;
              stale_addr_q <= cur_addr;
            end else begin
              state_q <= REQ;
            end
          end
        end
        REQ: begin
          if (instr_gnt_i) begin
            state_q <= IDLE;
          end else if (branch_i) begin
            state_q      <= REQ_STALE;
            stale_addr_q <= cur_addr;
          end
        end
        REQ_STALE: begin
          if (instr_gnt_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Fetch address. A branch loads the target. A non-stale grant steps to the next word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_addr_q <= 32'h0;
    end else if (branch_i) begin
      fetch_addr_q <= {branch_addr_i[31:2], 2'b00};
    end else if (gnt_acc && (state_q != REQ_STALE)) begin
      fetch_addr_q <= fetch_addr_q + 32'd4;
    end
  end

  // Outstanding-request counter: +1 per grant and -1 per accepted response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (gnt_acc && !rsp_acc) begin
      count_q <= count_q + 1'b1;
    end else if (!gnt_acc && rsp_acc) begin
      count_q <= count_q - 1'b1;
    end
  end

  // Next discard queue. A branch marks everything outstanding, a response pops the head,
  // and a grant appends at the tail.
  always_comb begin
    discard_d = discard_q;
    if (branch_i) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (CW'(i) < count_q) discard_d[i] = 1'b1;
      end
    end
    if (rsp_acc) discard_d = discard_d >> 1;
    if (gnt_acc) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (CW'(i) == slot) discard_d[i] = new_flag;
      end
    end
  end

  // Discard queue register, one flag per outstanding request with the oldest at bit 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) discard_q <= '0;
    else         discard_q <= discard_d;
  end

  // Bus rule: a response is never returned while nothing is outstanding.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_rvalid_i |-> (count_q != '0));

endmodule
